// File: rtl/fft2d_corner_turn.sv
// Corner-turn buffer between the row and column FFT stages: two ping-pong N*N banks,
// row-major input, column-major (or row-major) output with AXI-stream handshakes.
module fft2d_corner_turn #(
   parameter int N_LOG2 = 7,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s_tdata,
   input  logic              s_tvalid,
   output logic              s_tready,
   input  logic              s_tlast,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tlast,
   output logic              m_tuser,
   input  logic              transpose_en,
   output logic              err_tlast,
   output logic [1:0]        banks_full
);
   localparam int CNT_W = 2 * N_LOG2;
   localparam int DEPTH = 1 << CNT_W;

   typedef enum logic [1:0] {IDLE, PRIME, STREAM} rd_state_t;

   // write side
   logic             wr_bank_reg;
   logic [CNT_W-1:0] wr_cnt_reg;
   logic             err_tlast_reg;
   logic [1:0]       banks_full_reg;
   logic [1:0]       banks_full_next;
   logic             wr_fire;
   logic             wr_frame_end;
   logic             exp_tlast;

   // read side
   rd_state_t        state_reg;
   rd_state_t        state_next;
   logic             rd_bank_reg;
   logic [CNT_W-1:0] rd_cnt_reg;
   logic             rd_done_reg;
   logic             xpose_reg;
   logic             ram_re;
   logic [CNT_W-1:0] rd_addr;
   logic             issue_last;
   logic             issue_user;

   // q_* tracks the RAM output register, sk_* the spare entry of the skid pair
   logic              q_valid_reg;
   logic              q_last_reg;
   logic              q_user_reg;
   logic              q_bank_reg;
   logic              sk_valid_reg;
   logic              sk_last_reg;
   logic              sk_user_reg;
   logic [DATA_W-1:0] sk_data_reg;
   logic [1:0][DATA_W-1:0] bank_q;
   logic [DATA_W-1:0] q_data;
   logic              head_valid;
   logic              head_last;
   logic              head_user;
   logic              rd_fire;
   logic              frame_done;

   assign s_tready     = ~banks_full_reg[wr_bank_reg];
   assign wr_fire      = s_tvalid & s_tready;
   assign wr_frame_end = &wr_cnt_reg;
   assign exp_tlast    = &wr_cnt_reg[N_LOG2-1:0];
   assign err_tlast    = err_tlast_reg;
   assign banks_full   = banks_full_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_bank_reg    <= 1'b0;
         wr_cnt_reg     <= '0;
         err_tlast_reg  <= 1'b0;
         banks_full_reg <= 2'b00;
      end else begin
         banks_full_reg <= banks_full_next;
         if (wr_fire) begin
            wr_cnt_reg <= wr_cnt_reg + CNT_W'(1);
            if (wr_frame_end)
               wr_bank_reg <= ~wr_bank_reg;
            if (s_tlast != exp_tlast)
               err_tlast_reg <= 1'b1;
         end
      end
   end

   // Transposed readout swaps the row and column halves of the output index.
   assign rd_addr    = xpose_reg ? {rd_cnt_reg[N_LOG2-1:0], rd_cnt_reg[CNT_W-1:N_LOG2]}
                                 : rd_cnt_reg;
   assign issue_last = &rd_cnt_reg[N_LOG2-1:0];
   assign issue_user = &rd_cnt_reg;

   for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      logic [DATA_W-1:0] mem [DEPTH];
      logic [DATA_W-1:0] rd_q;

      always_ff @(posedge clk) begin
         if (wr_fire && wr_bank_reg == 1'(gi))
            mem[wr_cnt_reg] <= s_tdata;
         if (ram_re && rd_bank_reg == 1'(gi))
            rd_q <= mem[rd_addr];
      end

      assign bank_q[gi] = rd_q;
      // A bank is never filled and released at the same edge, so set and clear cannot collide.
      assign banks_full_next[gi] = (wr_fire && wr_frame_end && wr_bank_reg == 1'(gi)) ||
                                   (banks_full_reg[gi] && !(frame_done && rd_bank_reg == 1'(gi)));
   end

   assign q_data     = bank_q[q_bank_reg];
   assign head_valid = sk_valid_reg | q_valid_reg;
   assign head_last  = sk_valid_reg ? sk_last_reg : q_last_reg;
   assign head_user  = sk_valid_reg ? sk_user_reg : q_user_reg;
   assign rd_fire    = head_valid & m_tready;
   assign frame_done = rd_fire & head_user;

   assign m_tvalid = head_valid;
   assign m_tlast  = head_valid & head_last;
   assign m_tuser  = head_valid & head_user;
   assign m_tdata  = sk_valid_reg ? sk_data_reg : (q_valid_reg ? q_data : '0);

   always_comb begin
      state_next = state_reg;
      ram_re     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (banks_full_reg[rd_bank_reg])
               state_next = PRIME;
         end
         PRIME: begin
            ram_re     = 1'b1;
            state_next = STREAM;
         end
         STREAM: begin
            // Reads only issue into a free spare slot, keeping m_tready off the RAM enable path.
            ram_re = ~rd_done_reg & ~sk_valid_reg;
            if (frame_done)
               state_next = banks_full_reg[~rd_bank_reg] ? PRIME : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         rd_bank_reg  <= 1'b0;
         rd_cnt_reg   <= '0;
         rd_done_reg  <= 1'b0;
         xpose_reg    <= 1'b0;
         q_valid_reg  <= 1'b0;
         q_last_reg   <= 1'b0;
         q_user_reg   <= 1'b0;
         q_bank_reg   <= 1'b0;
         sk_valid_reg <= 1'b0;
         sk_last_reg  <= 1'b0;
         sk_user_reg  <= 1'b0;
         sk_data_reg  <= '0;
      end else begin
         state_reg <= state_next;
         if (state_next == PRIME && state_reg != PRIME)
            xpose_reg <= transpose_en;
         if (frame_done)
            rd_bank_reg <= ~rd_bank_reg;
         if (ram_re) begin
            rd_cnt_reg  <= rd_cnt_reg + CNT_W'(1);
            rd_done_reg <= &rd_cnt_reg;
         end

         if (ram_re) begin
            q_valid_reg <= 1'b1;
            q_last_reg  <= issue_last;
            q_user_reg  <= issue_user;
            q_bank_reg  <= rd_bank_reg;
         end else if (q_valid_reg && !sk_valid_reg && m_tready) begin
            q_valid_reg <= 1'b0;
         end

         // A stalled head is parked in the spare entry when a new read lands behind it.
         if (sk_valid_reg) begin
            if (m_tready)
               sk_valid_reg <= 1'b0;
         end else if (ram_re && q_valid_reg && !m_tready) begin
            sk_valid_reg <= 1'b1;
            sk_data_reg  <= q_data;
            sk_last_reg  <= q_last_reg;
            sk_user_reg  <= q_user_reg;
         end
      end
   end

endmodule
